spi_sram_ctrl: RTL and testbench

SPI_SRAM_CTRL -- requirements
Module: spi_sram_ctrl

---
 rtl/spi_sram_pkg.sv | 20 ++
 rtl/spi_shift_reg.sv | 30 +++
 rtl/spi_sram_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_sram_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared opcodes and FSM encoding for the SPI-to-SRAM bridge.
package spi_sram_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Generic MSB-first shift register with parallel load, used for
// both the serial-in command/data path and the serial-out read path.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    input  logic         i_din,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_din};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/spi_sram_ctrl.sv
// SPI slave bridging write (0x02) and streaming read (0x03) commands
// onto a simple strobe-based SRAM port, single clock domain on sck.
module spi_sram_ctrl
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sdi,
    output logic              sdo,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int IN_W  = max_int(8, DATA_W);
    localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_re;

    logic [IN_W-1:0]     w_in_q;
    logic [IN_W-1:0]     w_in_next;
    logic [7:0]          w_cmd;
    logic [DATA_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_out_q;
    logic                w_out_load;
    logic                w_out_shift;
    logic                w_unused;

    // Decode looks at the byte including the bit arriving on this edge.
    assign w_in_next = {w_in_q[IN_W-2:0], sdi};
    assign w_cmd     = w_in_next[7:0];
    assign w_word    = w_in_next[DATA_W-1:0];
    assign w_unused  = &{1'b0, w_in_q[IN_W-1]};

    spi_shift_reg #(.W(IN_W)) u_in_shift (
        .i_clk      (sck),
        .i_rst      (rst),
        .i_clr      (cs_n),
        .i_load     (1'b0),
        .i_load_val ({IN_W{1'b0}}),
        .i_shift    (1'b1),
        .i_din      (sdi),
        .o_q        (w_in_q)
    );

    // Read word arrives the edge after the strobe; otherwise shift out.
    assign w_out_load  = (r_state == ST_RDATA) && r_re;
    assign w_out_shift = (r_state == ST_RDATA) && !r_re;

    spi_shift_reg #(.W(DATA_W)) u_out_shift (
        .i_clk      (sck),
        .i_rst      (rst),
        .i_clr      (cs_n),
        .i_load     (w_out_load),
        .i_load_val (sram_rdata),
        .i_shift    (w_out_shift),
        .i_din      (1'b0),
        .o_q        (w_out_q)
    );

    always_ff @(posedge sck) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
        end else if (cs_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_state <= ST_CMD;
                    r_cnt   <= CNT_W'(1);
                end
                ST_CMD: begin
                    if (r_cnt == CNT_W'(7)) begin
                        r_cnt <= '0;
                        if (w_cmd == CMD_WRITE) begin
                            r_is_rd <= 1'b0;
                            r_state <= ST_ADDR;
                        end else if (w_cmd == CMD_READ) begin
                            r_is_rd <= 1'b1;
                            r_state <= ST_ADDR;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ADDR: begin
                    r_addr <= {r_addr[ADDR_W-2:0], sdi};
                    if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                        r_cnt <= '0;
                        if (r_is_rd) begin
                            r_state <= ST_RDATA;
                            r_re    <= 1'b1;
                        end else begin
                            r_state <= ST_WDATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WDATA: begin
                    if (r_we) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_cnt   <= '0;
                        r_wdata <= w_word;
                        r_we    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RDATA: begin
                    if (r_re) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Prefetch next word while bit 0 is still on sdo.
                        if (r_cnt == CNT_W'(DATA_W - 2)) begin
                            r_re   <= 1'b1;
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_ERR: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdo        = w_out_q[DATA_W-1];
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_we    = r_we;
    assign sram_re    = r_re;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Bench for spi_sram_ctrl: vector table of SPI transactions with a
// strobe scoreboard, plus abort and reset-mid-read sequences.
module tb_spi_sram_ctrl;
    import spi_sram_pkg::*;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        int          ndata;
        int          stop;
    } vec_t;

    typedef struct {
        logic        is_we;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        sck = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sdi;
    logic        sdo;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_we;
    logic        sram_re;
    logic [7:0]  sram_rdata;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    ev_t         sb[$];
    vec_t        vecs[5];
    int          n_checks = 0;
    int          n_err = 0;

    spi_sram_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
        .sck        (sck),
        .rst        (rst),
        .cs_n       (cs_n),
        .sdi        (sdi),
        .sdo        (sdo),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_re    (sram_re),
        .sram_rdata (sram_rdata)
    );

    always #5 sck = ~sck;

    always @(posedge sck) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = sram_re ? mem[sram_addr] : 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sck) begin
        ev_t e;
        if (sram_we === 1'b1 || sram_re === 1'b1) begin
            check("we_re_excl", 32'(sram_we & sram_re), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'({sram_we, sram_re}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 32'({sram_we, sram_re}),
                      e.is_we ? 32'd2 : 32'd1);
                check("strobe_addr", 32'(sram_addr), 32'(e.addr));
                if (e.is_we) check("we_data", 32'(sram_wdata), 32'(e.data));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [7:0]  bytes[$];
        logic [7:0]  rd[$];
        logic [7:0]  cur;
        logic [7:0]  db;
        logic [15:0] a;
        logic        d;
        logic        ex;
        bit          is_wr;
        bit          is_rd;
        int          nclk;
        ev_t         ev;
        is_wr = (v.op == CMD_WRITE);
        is_rd = (v.op == CMD_READ);
        bytes = {v.op, v.addr[15:8], v.addr[7:0]};
        if (!is_rd) begin
            for (int i = 0; i < v.ndata; i++)
                bytes.push_back(i == 0 ? v.data[15:8] : v.data[7:0]);
        end
        nclk = is_rd ? 25 + 8 * v.ndata : 8 * bytes.size();
        if (v.stop > 0) nclk = v.stop;
        if (is_wr) begin
            for (int i = 0; i < v.ndata; i++) begin
                if (32 + 8 * i <= nclk) begin
                    a = v.addr + 16'(i);
                    db = bytes[3 + i];
                    ev = '{1'b1, a, db};
                    sb.push_back(ev);
                    ref_mem[a] = db;
                end
            end
        end
        if (is_rd) begin
            for (int i = 0; i <= v.ndata; i++) begin
                if (24 + 8 * i <= nclk) begin
                    ev = '{1'b0, v.addr + 16'(i), 8'h00};
                    sb.push_back(ev);
                end
                if (i < v.ndata) rd.push_back(ref_mem[v.addr + 16'(i)]);
            end
        end
        for (int k = 0; k < nclk; k++) begin
            d = 1'b0;
            if (k < 8 * bytes.size()) begin
                cur = bytes[k / 8];
                d = cur[7 - k % 8];
            end
            ex = 1'b0;
            if (is_rd && k >= 25) begin
                cur = rd[(k - 25) / 8];
                ex = cur[7 - (k - 25) % 8];
            end
            @(negedge sck);
            check("sdo", 32'(sdo), 32'(ex));
            cs_n = 1'b0;
            sdi = d;
        end
        if (v.stop == 0) begin
            @(negedge sck);
            cs_n = 1'b1;
            sdi = 1'b0;
            @(negedge sck);
            check("sb_drained", 32'(sb.size()), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sdo"}, 32'(sdo), 32'd0);
        check({tag, "_we"}, 32'(sram_we), 32'd0);
        check({tag, "_re"}, 32'(sram_re), 32'd0);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
        check({tag, "_state"}, 32'(dut.r_state), 32'(ST_IDLE));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        vecs[0] = '{CMD_WRITE, 16'h0010, 16'hA53C, 2, 0};
        vecs[1] = '{CMD_READ,  16'h0010, 16'h0000, 2, 0};
        vecs[2] = '{CMD_WRITE, 16'hFFFF, 16'h1122, 2, 0};
        vecs[3] = '{CMD_READ,  16'hFFFF, 16'h0000, 2, 0};
        vecs[4] = '{8'h05,     16'h0310, 16'h5A00, 1, 0};

        rst = 1'b1;
        cs_n = 1'b1;
        sdi = 1'b0;
        repeat (3) @(negedge sck);
        check_zero("reset");
        rst = 1'b0;
        @(negedge sck);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        run_vec('{CMD_WRITE, 16'h0020, 16'hA800, 1, 29});
        @(negedge sck);
        cs_n = 1'b1;
        @(posedge sck);
        #1;
        check("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("abort_we", 32'(sram_we), 32'd0);
        @(negedge sck);
        check("abort_sb", 32'(sb.size()), 32'd0);
        run_vec('{CMD_READ, 16'h0020, 16'h0000, 1, 0});

        run_vec('{CMD_READ, 16'h0010, 16'h0000, 2, 29});
        @(negedge sck);
        rst = 1'b1;
        @(posedge sck);
        #1;
        check_zero("mid_rst");
        @(negedge sck);
        rst = 1'b0;
        cs_n = 1'b1;
        check("mid_rst_sb", 32'(sb.size()), 32'd0);
        run_vec('{CMD_READ, 16'h0010, 16'h0000, 2, 0});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
